// File: rtl/stream_burst_arb_pkg.sv
// Shared definitions for the burst-limited round-robin stream arbiter.
// Contents:
//   arb_state_e - arbiter FSM state (IDLE: no grant held, GRANT: one input owns the output)
package stream_burst_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/stream_burst_arb_chk.sv
// stream_burst_arb_chk: simulation-only protocol checks for stream_burst_arb.
// Present only when STREAM_BURST_ARB_ASSERT_EN is defined.
// Ports: clk_i, rst_ni, and observation copies of the arbiter's ready vector,
// output handshake signals, output payload and burst credit register.
`ifdef STREAM_BURST_ARB_ASSERT_EN
module stream_burst_arb_chk #(
  parameter type         DATA_T    = logic,
  parameter int unsigned N_INP     = 2,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic [N_INP-1:0] inp_ready_o,
  input logic             oup_valid_o,
  input logic             oup_ready_i,
  input DATA_T            oup_data_o,
  input logic [CNT_W-1:0] credit_q
);

  logic  stall_r;
  DATA_T data_r;

  // Remember whether the previous cycle was an output stall.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_r <= 1'b0;
    end else begin
      stall_r <= oup_valid_o & ~oup_ready_i;
    end
  end

  // Payload seen during the previous cycle, compared only after a stall.
  always_ff @(posedge clk_i) begin
    data_r <= oup_data_o;
  end

  // Protocol and range checks evaluated every active clock edge.
  always @(posedge clk_i) begin
    a_params: assert (N_INP >= 2 && MAX_BURST >= 1)
      else $error("stream_burst_arb: illegal parameters");
    if (rst_ni) begin
      a_ready_onehot: assert ($onehot0(inp_ready_o))
        else $error("stream_burst_arb: inp_ready_o not one-hot");
      a_credit_range: assert (credit_q <= CNT_W'(MAX_BURST))
        else $error("stream_burst_arb: credit above MAX_BURST");
      if (stall_r) begin
        a_stall_stable: assert (oup_valid_o && (oup_data_o == data_r))
          else $error("stream_burst_arb: stalled input changed");
      end
    end
  end

endmodule
`endif

// File: rtl/stream_burst_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first requesting index found by searching upward from ptr_i,
// wrapping from N_INP-1 back to 0, so every input is covered exactly once.
// Ports:
//   req_i [N_INP]     - request vector
//   ptr_i [LOG_N_INP] - search start index (must be < N_INP)
//   idx_o [LOG_N_INP] - picked index (0 when no request)
//   any_o             - at least one request present
module rr_pick #(
  parameter int unsigned N_INP     = 2,
  parameter int unsigned LOG_N_INP = $clog2(N_INP)
) (
  input  logic [N_INP-1:0]     req_i,
  input  logic [LOG_N_INP-1:0] ptr_i,
  output logic [LOG_N_INP-1:0] idx_o,
  output logic                 any_o
);

  logic [LOG_N_INP-1:0] hi_idx_s;
  logic [LOG_N_INP-1:0] lo_idx_s;
  logic                 hi_any_s;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_idx_s = {LOG_N_INP{1'b0}};
    lo_idx_s = {LOG_N_INP{1'b0}};
    hi_any_s = 1'b0;
    // Descending scan so the last hit kept is the lowest index.
    for (int i = N_INP - 1; i >= 0; i--) begin
      lo_idx_s = req_i[i] ? LOG_N_INP'(i) : lo_idx_s;
      hi_idx_s = (req_i[i] && (LOG_N_INP'(i) >= ptr_i)) ? LOG_N_INP'(i) : hi_idx_s;
      hi_any_s = hi_any_s | (req_i[i] && (LOG_N_INP'(i) >= ptr_i));
    end
    idx_o = hi_any_s ? hi_idx_s : lo_idx_s;
    any_o = |req_i;
  end

endmodule

// File: rtl/stream_burst_arb.sv
// stream_burst_arb: round-robin arbiter of N_INP valid/ready streams onto one
// output, holding each grant for at most MAX_BURST consecutive handshakes.
// Optional checks: define STREAM_BURST_ARB_ASSERT_EN to compile in assertions.
// Ports:
//   clk_i, rst_ni            - clock, synchronous active-low reset
//   inp_data_i/valid_i/ready_o - N_INP input streams
//   oup_data_o/valid_o/ready_i - arbitrated output stream
//   sel_o                    - granted input index (don't-care while idle)
//   idle_o                   - no grant held
module stream_burst_arb
  import stream_burst_arb_pkg::*;
#(
  parameter type         DATA_T    = logic,
  parameter int unsigned N_INP     = 2,
  parameter int unsigned MAX_BURST = 4,
  // Derived; keep at their defaults.
  parameter int unsigned LOG_N_INP = $clog2(N_INP),
  parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  DATA_T                inp_data_i [N_INP],
  input  logic [N_INP-1:0]     inp_valid_i,
  output logic [N_INP-1:0]     inp_ready_o,
  output DATA_T                oup_data_o,
  output logic                 oup_valid_o,
  input  logic                 oup_ready_i,
  output logic [LOG_N_INP-1:0] sel_o,
  output logic                 idle_o
);

  localparam logic [CNT_W-1:0]     CREDIT_FULL = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]     CREDIT_ONE  = CNT_W'(1);
  localparam logic [LOG_N_INP-1:0] LAST_IDX    = LOG_N_INP'(N_INP - 1);

  arb_state_e           state_q, state_d;
  logic [LOG_N_INP-1:0] sel_q, sel_d;
  logic [LOG_N_INP-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     credit_q, credit_d;

  logic [LOG_N_INP-1:0] next_ptr_s;
  logic [LOG_N_INP-1:0] pick_ptr_s;
  logic [LOG_N_INP-1:0] pick_idx_s;
  logic                 pick_any_s;
  logic                 sel_valid_s;
  logic                 hs_s;
  logic                 release_s;

  // Pointer just past the current grant, wrapping for non-power-of-two N_INP.
  assign next_ptr_s  = (sel_q == LAST_IDX) ? {LOG_N_INP{1'b0}} : sel_q + LOG_N_INP'(1);
  // While granted the picker is only consulted on release, so feed it the
  // post-release pointer; this is what allows a regrant in the same cycle.
  assign pick_ptr_s  = (state_q == GRANT) ? next_ptr_s : ptr_q;
  assign sel_valid_s = inp_valid_i[sel_q];
  assign hs_s        = (state_q == GRANT) & sel_valid_s & oup_ready_i;
  assign release_s   = (state_q == GRANT) & ((hs_s & (credit_q == CREDIT_ONE)) | ~sel_valid_s);

  rr_pick #(
    .N_INP     (N_INP),
    .LOG_N_INP (LOG_N_INP)
  ) u_pick (
    .req_i (inp_valid_i),
    .ptr_i (pick_ptr_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  // Next-state and output logic of the grant FSM.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    inp_ready_o = {N_INP{1'b0}};
    oup_valid_o = 1'b0;
    idle_o      = 1'b1;
    oup_data_o  = inp_data_i[sel_q];

    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d  = GRANT;
          sel_d    = pick_idx_s;
          credit_d = CREDIT_FULL;
        end else begin
          state_d  = IDLE;
        end
      end
      GRANT: begin
        // Ready depends only on registered selection and oup_ready_i.
        inp_ready_o[sel_q] = oup_ready_i;
        oup_valid_o        = sel_valid_s;
        idle_o             = 1'b0;
        if (release_s) begin
          ptr_d = next_ptr_s;
          if (pick_any_s) begin
            sel_d    = pick_idx_s;
            credit_d = CREDIT_FULL;
          end else begin
            state_d  = IDLE;
            credit_d = hs_s ? (credit_q - CREDIT_ONE) : credit_q;
          end
        end else if (hs_s) begin
          credit_d = credit_q - CREDIT_ONE;
        end else begin
          credit_d = credit_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and grant bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sel_q    <= {LOG_N_INP{1'b0}};
      ptr_q    <= {LOG_N_INP{1'b0}};
      credit_q <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign sel_o = sel_q;

`ifdef STREAM_BURST_ARB_ASSERT_EN
  stream_burst_arb_chk #(
    .DATA_T    (DATA_T),
    .N_INP     (N_INP),
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inp_ready_o (inp_ready_o),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .oup_data_o  (oup_data_o),
    .credit_q    (credit_q)
  );
`else
  // No checker instance in the default build.
`endif

endmodule

// File: tb/tb_stream_burst_arb.sv
// Testbench for stream_burst_arb: two instances (N_INP=3 with MAX_BURST=4 and
// MAX_BURST=1) checked every cycle against a behavioural owner/beats model,
// with directed scenarios followed by randomized traffic.
module tb_stream_burst_arb;

  logic clk;
  logic rst_n;

  logic [1:0][2:0][7:0] dp;
  logic [1:0][2:0]      vv;
  logic [1:0]           rr;
  logic [7:0]           du0 [3];
  logic [7:0]           du1 [3];

  logic [1:0][2:0] o_ready;
  logic [1:0][7:0] o_data;
  logic [1:0]      o_valid;
  logic [1:0][1:0] o_sel;
  logic [1:0]      o_idle;
  logic [1:0][2:0] o_cred;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the output, beats left, where the next search starts.
  int owner [2];
  int beats [2];
  int nstart [2];
  int maxb [2];
  int stall_hold [2];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      du0[i] = dp[0][i];
      du1[i] = dp[1][i];
    end
  end

  assign o_cred[0] = dut.credit_q;
  assign o_cred[1] = {2'b00, dut1.credit_q};

  stream_burst_arb #(.DATA_T(logic [7:0]), .N_INP(3), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .inp_data_i(du0), .inp_valid_i(vv[0]),
    .inp_ready_o(o_ready[0]), .oup_data_o(o_data[0]), .oup_valid_o(o_valid[0]),
    .oup_ready_i(rr[0]), .sel_o(o_sel[0]), .idle_o(o_idle[0])
  );

  stream_burst_arb #(.DATA_T(logic [7:0]), .N_INP(3), .MAX_BURST(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .inp_data_i(du1), .inp_valid_i(vv[1]),
    .inp_ready_o(o_ready[1]), .oup_data_o(o_data[1]), .oup_valid_o(o_valid[1]),
    .oup_ready_i(rr[1]), .sel_o(o_sel[1]), .idle_o(o_idle[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_valid(input logic [2:0] v, input int start);
    for (int off = 0; off < 3; off++) begin
      if (v[(start + off) % 3]) return (start + off) % 3;
    end
    return -1;
  endfunction

  // One clock cycle: compare outputs with the model, advance the model, move to next negedge.
  task automatic tick();
    logic hs;
    logic [2:0] exp_rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_rdy = 3'b000;
      if (owner[k] >= 0 && rr[k]) exp_rdy = 3'b001 << owner[k];
      check_eq($sformatf("valid%0d", k), o_valid[k], (owner[k] >= 0) ? vv[k][owner[k]] : 1'b0);
      check_eq($sformatf("idle%0d", k), o_idle[k], (owner[k] < 0) ? 1'b1 : 1'b0);
      check_eq($sformatf("ready%0d", k), o_ready[k], exp_rdy);
      if (owner[k] >= 0) begin
        check_eq($sformatf("sel%0d", k), o_sel[k], owner[k]);
        check_eq($sformatf("credit%0d", k), o_cred[k], beats[k]);
        if (vv[k][owner[k]]) check_eq($sformatf("data%0d", k), o_data[k], dp[k][owner[k]]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      hs = (owner[k] >= 0) && vv[k][owner[k]] && rr[k];
      stall_hold[k] = (owner[k] >= 0 && vv[k][owner[k]] && !rr[k]) ? owner[k] : -1;
      if (!rst_n) begin
        owner[k] = -1; beats[k] = 0; nstart[k] = 0; stall_hold[k] = -1;
      end else if (owner[k] < 0) begin
        if (|vv[k]) begin
          owner[k] = first_valid(vv[k], nstart[k]);
          beats[k] = maxb[k];
        end
      end else begin
        if (hs) beats[k]--;
        if ((hs && beats[k] == 0) || !vv[k][owner[k]]) begin
          nstart[k] = (owner[k] + 1) % 3;
          if (|vv[k]) begin
            owner[k] = first_valid(vv[k], nstart[k]);
            beats[k] = maxb[k];
          end else begin
            owner[k] = -1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vv = '0;
    rr = 2'b00;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int dens;
    clk = 1'b0;
    rst_n = 1'b0;
    vv = '0; rr = 2'b00; dp = '0;
    maxb[0] = 4; maxb[1] = 1;
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; beats[k] = 0; nstart[k] = 0; stall_hold[k] = -1;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_idle%0d", k), o_idle[k], 1'b1);
      check_eq($sformatf("rst_valid%0d", k), o_valid[k], 1'b0);
      check_eq($sformatf("rst_ready%0d", k), o_ready[k], 3'b000);
      check_eq($sformatf("rst_sel%0d", k), o_sel[k], 2'd0);
      check_eq($sformatf("rst_credit%0d", k), o_cred[k], 3'd0);
    end
    do_reset();

    // All inputs valid: 4-beat rotation on dut, 0/2 alternation on the single-beat instance.
    vv[0] = 3'b111; vv[1] = 3'b101; rr = 2'b11;
    for (int i = 0; i < 3; i++) begin
      dp[0][i] = 8'h10 + 8'(i);
      dp[1][i] = 8'h20 + 8'(i);
    end
    tick();
    for (int c = 0; c < 24; c++) begin
      #1;
      check_eq("rot_sel", o_sel[0], (c / 4) % 3);
      check_eq("rot_valid", o_valid[0], 1'b1);
      check_eq("alt_sel", o_sel[1], (c % 2) ? 2 : 0);
      check_eq("alt_valid", o_valid[1], 1'b1);
      tick();
    end

    // Sole requester 2: release then immediate regrant of itself.
    do_reset();
    vv[0] = 3'b100; rr[0] = 1'b1;
    tick();
    for (int c = 0; c < 9; c++) begin
      #1;
      check_eq("solo_sel", o_sel[0], 2'd2);
      check_eq("solo_valid", o_valid[0], 1'b1);
      check_eq("solo_credit", o_cred[0], 4 - (c % 4));
      tick();
    end

    // Stall on input 1 holds everything, then the credit drains.
    do_reset();
    vv[0] = 3'b010; rr[0] = 1'b0; dp[0][1] = 8'h5a;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("stall_sel", o_sel[0], 2'd1);
      check_eq("stall_data", o_data[0], 8'h5a);
      check_eq("stall_credit", o_cred[0], 3'd4);
      tick();
    end
    rr[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("drain_credit", o_cred[0], 4 - c);
      check_eq("drain_valid", o_valid[0], 1'b1);
      tick();
    end

    // Granted input drops valid after two beats: move to input 2 with full credit.
    do_reset();
    vv[0] = 3'b001; rr[0] = 1'b1;
    tick(); tick(); tick();
    vv[0] = 3'b100;
    #1;
    check_eq("drop_sel", o_sel[0], 2'd0);
    check_eq("drop_valid", o_valid[0], 1'b0);
    tick();
    #1;
    check_eq("drop_newsel", o_sel[0], 2'd2);
    check_eq("drop_credit", o_cred[0], 3'd4);
    tick();

    // Reset during the third beat of a burst.
    do_reset();
    vv[0] = 3'b111; rr[0] = 1'b1;
    tick(); tick(); tick();
    #1;
    check_eq("midrst_beat3_valid", o_valid[0], 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("midrst_valid", o_valid[0], 1'b0);
    check_eq("midrst_idle", o_idle[0], 1'b1);
    check_eq("midrst_ready", o_ready[0], 3'b000);
    tick();
    #1;
    check_eq("midrst_regrant_sel", o_sel[0], 2'd0);
    tick();

    // Randomized traffic; a stalled granted input keeps its valid and data.
    dens = 2;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) dens = $urandom_range(1, 3);
      rst_n = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) begin
          if (stall_hold[k] != i) begin
            vv[k][i] = ($urandom_range(0, 3) < dens);
            dp[k][i] = 8'($urandom);
          end
        end
        rr[k] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
